tdm_demux_1_4: RTL and testbench
================================

# tdm_demux_1_4

Time-division demultiplexer that turns one W-bit lane, carrying four interleaved slots per frame, back into four parallel W-bit lanes. It is the receive end of the 4:1 slot-select path used by the barrel-shifter datapath. The block locks onto a start-of-frame marker, captures slot 0..3 into holding registers, and presents a complete frame with a one-cycle valid pulse. Framing errors drop the partial frame and force a resync.

## Interface
- W, default 1: width of each lane and of the serial input.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  slot data; sampled only when din_valid=1.
- din_valid  input  1  din carries a slot this cycle.
- sof  input  1  qualifies din as slot 0 of a new frame; ignored when din_valid=0.
- y_out  output  4*W  frame register; lane k at bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse; y_out updated this cycle.
- sync_err  output  1  one-cycle pulse on a framing violation.
- locked  output  1  high while in LOCKED state.

## Operation
- States: HUNT (reset state) and LOCKED. Slot counter slot[1:0].
- HUNT: beats without sof are dropped silently. A beat with sof captures din into lane 0, sets slot=1, and goes to LOCKED.
- LOCKED, beat with slot=1..3 and sof=0: capture din into lane[slot] and increment slot.
- LOCKED, beat with slot=3: after capture, copy lanes 0..3 into y_out, pulse frame_valid and wrap slot to 0.
- LOCKED, beat with slot=0: sof is required. If sof=1, capture lane 0 and set slot=1. If sof=0, pulse sync_err, drop the beat and go to HUNT.
- LOCKED, beat with sof=1 while slot≠0: pulse sync_err and discard the partial frame. This beat is treated as slot 0 of a new frame: capture lane 0, set slot=1, stay LOCKED.
- Cycles with din_valid=0 do not advance slot and have no timeout.
- y_out holds the last good frame until the next complete frame. Partial frames never reach y_out.
- Capture enables are a one-hot decode of slot, gated by din_valid.

## Timing
- Reset values: y_out=0, frame_valid=0, sync_err=0, locked=0, state=HUNT, slot=0. The lane holding registers also reset to 0.
- All outputs are registered.
- Latency: y_out and frame_valid change in the cycle after the clock edge that samples slot 3.
- Back-to-back frames are supported at one beat per cycle: a 4-cycle frame period gives frame_valid every 4th cycle.
- Reset asserted mid-frame clears everything immediately. The first beat after reset needs sof.
- frame_valid and sync_err are never both high in the same cycle unless DEMUX_PARITY_EN is defined (see below).

## Configuration
- DEMUX_PARITY_EN defined: each frame carries a fifth slot (slot=4, counter widened to 3 bits).
  - din[0] of that slot is even parity over all 4*W lane bits.
  - On a match, y_out updates and frame_valid pulses after the parity beat.
  - On a mismatch, sync_err pulses, y_out is unchanged, and the block stays LOCKED.
  - sof during the parity slot is a framing violation and follows the same rule as sof while slot≠0.
- DEMUX_PARITY_EN undefined: 4-slot frames, no parity logic, behaviour exactly as above.

## Structure
- Shared package tdm_pkg:
  - SLOTS_PER_FRAME constant (4, or 5 with parity).
  - Slot-index typedef.
  - State enum {HUNT, LOCKED}.
- One sub-module, tdm_slot_decoder: combinational slot index plus enable to one-hot lane capture enables. It is the inverse of the slot-select mux.

## Test plan
Cases 1–5 use W=4.
1. Reset, then beats sof+0x1, 0x2, 0x3, 0x4 on consecutive cycles -> next cycle y_out=0x4321, frame_valid=1 for one cycle, locked=1.
2. Two frames back-to-back (0xA,0xB,0xC,0xD then 0x1,0x2,0x3,0x4), with din_valid dropped for 2 cycles mid-second-frame -> y_out=0xDCBA, then 0x4321; exactly two frame_valid pulses.
3. Beats sof+0x5, 0x6, then sof+0x7, 0x8, 0x9, 0xA -> sync_err pulses on the second sof; y_out=0xA987; 0x5 and 0x6 never appear.
4. While LOCKED after a full frame, a beat with sof=0 at slot 0 -> sync_err, locked=0; subsequent non-sof beats are ignored until sof.
5. Assert rst_n=0 after two slots of a frame -> all outputs return to 0 asynchronously; a following complete frame decodes correctly.
6. DEMUX_PARITY_EN defined, W=1: frame 1,0,1,1 with parity 1 -> y_out=0b1101, frame_valid=1. Same frame with parity 0 -> sync_err=1, y_out unchanged.

Source files
------------

// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the 1:4 TDM demultiplexer.
//
// Configuration macro: DEMUX_PARITY_EN
//   undefined : four slots per frame, 2-bit slot counter.
//   defined   : a fifth parity slot follows the four data slots, 3-bit counter.
//
// Contents:
//   SLOTS_PER_FRAME : beats per frame (4, or 5 with the parity slot)
//   LANES           : number of parallel output lanes (always 4)
//   slot_t          : slot-index type
//   LAST_SLOT       : index of the final beat of a frame
//   state_t         : framing FSM states {HUNT, LOCKED}
// -----------------------------------------------------------------------------
package tdm_pkg;

`ifdef DEMUX_PARITY_EN
  localparam int SLOTS_PER_FRAME = 5;
  localparam int SLOT_W          = 3;
`else
  localparam int SLOTS_PER_FRAME = 4;
  localparam int SLOT_W          = 2;
`endif

  localparam int LANES = 4;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(SLOTS_PER_FRAME - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_decoder.sv
// -----------------------------------------------------------------------------
// tdm_slot_decoder
// Combinational one-hot decode of a slot index into lane capture enables.
// It is the inverse of the transmit-side slot-select mux: exactly one lane
// enable is raised for slot indices 0..LANES-1 when en is high. Indices at or
// beyond LANES (the parity slot) raise no enable.
//
// Ports:
//   slot   in   slot_t       slot index of the current beat
//   en     in   1            beat is to be captured
//   cap_en out  LANES        one-hot lane capture enables
// -----------------------------------------------------------------------------
module tdm_slot_decoder
  import tdm_pkg::*;
(
  input  slot_t            slot,
  input  logic             en,
  output logic [LANES-1:0] cap_en
);

  always_comb begin
    cap_en = '0;
    for (int k = 0; k < LANES; k++) begin
      if (en && (slot == slot_t'(k))) begin
        cap_en[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_demux_1_4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1_4
// Receive end of the 4:1 slot-select path. Locks onto a start-of-frame marker,
// captures slots 0..3 into lane holding registers and publishes a complete
// frame on y_out with a one-cycle frame_valid pulse. Framing violations pulse
// sync_err and drop the partial frame; partial frames never reach y_out.
//
// Configuration macro: DEMUX_PARITY_EN
//   When defined, each frame carries a fifth beat whose din[0] is even parity
//   over all 4*W lane bits; a mismatch pulses sync_err and y_out is kept.
//
// Handshake: a beat is transferred on every rising edge where din_valid=1;
//   there is no back-pressure. sof is only meaningful together with din_valid.
//   Cycles with din_valid=0 neither advance the slot counter nor time out.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   din          in   W      slot data
//   din_valid    in   1      din carries a slot this cycle
//   sof          in   1      din is slot 0 of a new frame
//   y_out        out  4*W    frame register, lane k at [k*W +: W]
//   frame_valid  out  1      one-cycle pulse when y_out updates
//   sync_err     out  1      one-cycle pulse on a framing violation
//   locked       out  1      framing FSM state (1 = LOCKED, 0 = HUNT)
// -----------------------------------------------------------------------------
module tdm_demux_1_4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sof,
  output logic [4*W-1:0] y_out,
  output logic           frame_valid,
  output logic           sync_err,
  output logic           locked
);

  state_t               state;
  slot_t                slot;
  logic [LANES*W-1:0]   lanes_q;
  logic [LANES*W-1:0]   lanes_next;
  logic [LANES-1:0]     cap_en;
  slot_t                dec_slot;
  logic                 dec_en;

  // A sof beat always restarts at slot 0, whatever the counter says. Non-sof
  // beats are only captured while locked and past slot 0; in HUNT the counter
  // sits at 0, so this also drops non-sof beats while hunting.
  assign dec_slot = sof ? '0 : slot;
  assign dec_en   = din_valid && (sof || ((state == LOCKED) && (slot != '0)));

  tdm_slot_decoder u_slot_decoder (
    .slot   (dec_slot),
    .en     (dec_en),
    .cap_en (cap_en)
  );

  // Lane contents after this edge. The last data beat is forwarded straight
  // into y_out from here so the frame appears one cycle after that beat.
  always_comb begin
    lanes_next = lanes_q;
    for (int k = 0; k < LANES; k++) begin
      if (cap_en[k]) begin
        lanes_next[k*W +: W] = din;
      end
    end
  end

  // The FSM state is visible directly on the locked output.
  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= '0;
      lanes_q     <= '0;
      y_out       <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      lanes_q     <= lanes_next;
      if (din_valid) begin
        if (sof) begin
          // sof mid-frame: report it, then treat this beat as slot 0.
          if ((state == LOCKED) && (slot != '0)) begin
            sync_err <= 1'b1;
          end
          state <= LOCKED;
          slot  <= slot_t'(1);
        end else if (state == LOCKED) begin
          if (slot == '0) begin
            // Missing sof at a frame boundary: lose lock.
            sync_err <= 1'b1;
            state    <= HUNT;
          end else if (slot == LAST_SLOT) begin
            slot <= '0;
`ifdef DEMUX_PARITY_EN
            if (din[0] == (^lanes_q)) begin
              y_out       <= lanes_q;
              frame_valid <= 1'b1;
            end else begin
              sync_err <= 1'b1;
            end
`else
            y_out       <= lanes_next;
            frame_valid <= 1'b1;
`endif
          end else begin
            slot <= slot + slot_t'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1_4
// Directed bench for tdm_demux_1_4. Expected frames are pushed into exp_q as
// stimulus is issued; a negedge monitor pops and compares on every
// frame_valid pulse. Default build runs the 4-slot cases with W=4; with
// DEMUX_PARITY_EN defined it runs the parity case with W=1.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1_4;

`ifdef DEMUX_PARITY_EN
  localparam int W = 1;
`else
  localparam int W = 4;
`endif

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           sof;
  logic [4*W-1:0] y_out;
  logic           frame_valid;
  logic           sync_err;
  logic           locked;

  logic [4*W-1:0] exp_q[$];
  int             checks;
  int             errors;
  int             seen_fv;
  int             seen_err;

  tdm_demux_1_4 #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .y_out       (y_out),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic beat(input logic s, input logic [W-1:0] d);
    din_valid = 1'b1;
    sof       = s;
    din       = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string name);
    int budget;
    budget = 20;
    while ((exp_q.size() != 0) && (budget > 0)) begin
      idle(1);
      budget--;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        seen_fv++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: actual y_out=%0h expected no frame", y_out);
        end else begin
          logic [4*W-1:0] e;
          e = exp_q.pop_front();
          if (y_out !== e) begin
            errors++;
            $display("FAIL frame_data: actual y_out=%0h expected=%0h", y_out, e);
          end
        end
      end
      if (sync_err) seen_err++;
`ifndef DEMUX_PARITY_EN
      if (frame_valid && sync_err) begin
        checks++;
        errors++;
        $display("FAIL fv_err_exclusive: actual both=1 expected at most one");
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int fv0;
    int err0;
    checks    = 0;
    errors    = 0;
    seen_fv   = 0;
    seen_err  = 0;
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sof       = 1'b0;
    idle(3);
    chk("reset_y_out", 64'(y_out), 64'd0);
    chk("reset_frame_valid", 64'(frame_valid), 64'd0);
    chk("reset_sync_err", 64'(sync_err), 64'd0);
    chk("reset_locked", 64'(locked), 64'd0);
    rst_n = 1'b1;
    idle(1);

`ifndef DEMUX_PARITY_EN
    // Case 1: single frame, latency check.
    exp_q.push_back(16'h4321);
    beat(1'b1, 4'h1);
    chk("c1_locked_after_sof", 64'(locked), 64'd1);
    beat(1'b0, 4'h2);
    beat(1'b0, 4'h3);
    chk("c1_no_early_fv", 64'(frame_valid), 64'd0);
    beat(1'b0, 4'h4);
    chk("c1_fv", 64'(frame_valid), 64'd1);
    chk("c1_y_out", 64'(y_out), 64'h4321);
    idle(1);
    chk("c1_fv_one_cycle", 64'(frame_valid), 64'd0);
    chk("c1_locked", 64'(locked), 64'd1);
    drain("c1_drain");

    // Case 2: back-to-back frames with a gap inside the second.
    fv0 = seen_fv;
    exp_q.push_back(16'hDCBA);
    exp_q.push_back(16'h4321);
    beat(1'b1, 4'hA);
    beat(1'b0, 4'hB);
    beat(1'b0, 4'hC);
    beat(1'b0, 4'hD);
    beat(1'b1, 4'h1);
    beat(1'b0, 4'h2);
    idle(2);
    chk("c2_y_out_hold", 64'(y_out), 64'hDCBA);
    beat(1'b0, 4'h3);
    beat(1'b0, 4'h4);
    idle(2);
    drain("c2_drain");
    chk("c2_fv_count", 64'(seen_fv - fv0), 64'd2);

    // Case 3: sof mid-frame restarts; the partial frame is dropped.
    err0 = seen_err;
    exp_q.push_back(16'hA987);
    beat(1'b1, 4'h5);
    beat(1'b0, 4'h6);
    beat(1'b1, 4'h7);
    chk("c3_sync_err", 64'(sync_err), 64'd1);
    chk("c3_still_locked", 64'(locked), 64'd1);
    beat(1'b0, 4'h8);
    beat(1'b0, 4'h9);
    beat(1'b0, 4'hA);
    idle(2);
    drain("c3_drain");
    chk("c3_y_out", 64'(y_out), 64'hA987);
    chk("c3_err_count", 64'(seen_err - err0), 64'd1);

    // Case 4: missing sof at slot 0 loses lock; non-sof beats are ignored.
    fv0 = seen_fv;
    beat(1'b0, 4'h5);
    chk("c4_sync_err", 64'(sync_err), 64'd1);
    chk("c4_unlocked", 64'(locked), 64'd0);
    beat(1'b0, 4'h1);
    beat(1'b0, 4'h2);
    beat(1'b0, 4'h3);
    beat(1'b0, 4'h4);
    idle(2);
    chk("c4_still_unlocked", 64'(locked), 64'd0);
    chk("c4_no_frame", 64'(seen_fv - fv0), 64'd0);
    chk("c4_y_out_hold", 64'(y_out), 64'hA987);
    exp_q.push_back(16'hEDCB);
    beat(1'b1, 4'hB);
    beat(1'b0, 4'hC);
    beat(1'b0, 4'hD);
    beat(1'b0, 4'hE);
    idle(2);
    drain("c4_drain");

    // Case 5: asynchronous reset mid-frame.
    beat(1'b1, 4'h1);
    beat(1'b0, 4'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("c5_async_y_out", 64'(y_out), 64'd0);
    chk("c5_async_locked", 64'(locked), 64'd0);
    chk("c5_async_fv", 64'(frame_valid), 64'd0);
    chk("c5_async_err", 64'(sync_err), 64'd0);
    idle(2);
    rst_n = 1'b1;
    beat(1'b0, 4'h9);
    chk("c5_needs_sof", 64'(locked), 64'd0);
    exp_q.push_back(16'h6543);
    beat(1'b1, 4'h3);
    beat(1'b0, 4'h4);
    beat(1'b0, 4'h5);
    beat(1'b0, 4'h6);
    idle(2);
    drain("c5_drain");
    chk("c5_y_out", 64'(y_out), 64'h6543);
`else
    // Case 6: parity slot, W=1. Lanes 1,0,1,1 -> xor 1.
    exp_q.push_back(4'b1101);
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    chk("c6_no_fv_before_parity", 64'(frame_valid), 64'd0);
    beat(1'b0, 1'b1);
    chk("c6_fv", 64'(frame_valid), 64'd1);
    chk("c6_y_out", 64'(y_out), 64'b1101);
    idle(2);
    drain("c6_drain");
    err0 = seen_err;
    fv0  = seen_fv;
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    chk("c6_parity_err", 64'(sync_err), 64'd1);
    idle(2);
    chk("c6_err_count", 64'(seen_err - err0), 64'd1);
    chk("c6_no_frame", 64'(seen_fv - fv0), 64'd0);
    chk("c6_y_out_hold", 64'(y_out), 64'b1101);
    chk("c6_locked", 64'(locked), 64'd1);
`endif

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
